// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, waits on the memory handshake and traps on
// illegal opcodes or memory timeouts.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       link_to_pc,
    output logic       reg_dst,
    output logic       is_branch,
    output logic       is_jump,
    output logic       jr_sel,
    output logic [2:0] command,
    output logic       retired,
    output logic       trap,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpJal  = 6'h03;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpBne  = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpXori = 6'h0E;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] CmdAdd = 3'd0;
    localparam logic [2:0] CmdSub = 3'd1;
    localparam logic [2:0] CmdXor = 3'd2;
    localparam logic [2:0] CmdSlt = 3'd3;

    // Last count value before a stalled memory wait gives up.
    localparam logic [CNT_W-1:0] CntLast =
        CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam bit TimeoutEn = (MEM_TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic waiting;
    logic timeout_hit;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OpR:                                        return fn inside {FnAdd, FnSub, FnSlt, FnJr};
            OpJ, OpJal, OpBeq, OpBne, OpAddi, OpXori,
            OpLw, OpSw:                                 return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    assign waiting     = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

    // State register, instruction latches and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, opcode latching and wait-counter update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;

        unique case (state_q)
            StFetch: begin
                if (mem_ready)        state_d = StDecode;
                else if (timeout_hit) state_d = StTrap;
            end
            StDecode: begin
                op_d    = opcode;
                funct_d = funct;
                state_d = is_legal(opcode, funct) ? StExec : StTrap;
            end
            StExec: begin
                case (op_q)
                    OpR:            state_d = (funct_q == FnJr) ? StFetch : StWb;
                    OpAddi, OpXori: state_d = StWb;
                    OpLw, OpSw:     state_d = StMem;
                    default:        state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready)        state_d = (op_q == OpLw) ? StWb : StFetch;
                else if (timeout_hit) state_d = StTrap;
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Counter restarts on any state change and saturates instead of wrapping.
        if (state_d != state_q)                        cnt_d = '0;
        else if (waiting && TimeoutEn && !timeout_hit) cnt_d = cnt_q + 1'b1;
        else                                           cnt_d = cnt_q;
    end

    // Per-state datapath enables.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        link_to_pc = 1'b0;
        reg_dst    = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        jr_sel     = 1'b0;
        command    = CmdAdd;
        retired    = 1'b0;
        trap       = (state_q == StTrap);
        state      = state_q;

        unique case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            StExec: begin
                case (op_q)
                    OpR: begin
                        if (funct_q == FnJr) begin
                            is_jump  = 1'b1;
                            jr_sel   = 1'b1;
                            pc_write = 1'b1;
                            retired  = 1'b1;
                        end else begin
                            case (funct_q)
                                FnSub:   command = CmdSub;
                                FnSlt:   command = CmdSlt;
                                default: command = CmdAdd;
                            endcase
                        end
                    end
                    OpAddi, OpLw, OpSw: alu_src = 1'b1;
                    OpXori: begin
                        alu_src = 1'b1;
                        command = CmdXor;
                    end
                    OpBeq, OpBne: begin
                        command   = CmdSub;
                        is_branch = 1'b1;
                        pc_write  = (op_q == OpBeq) ? zero : !zero;
                        retired   = 1'b1;
                    end
                    OpJ, OpJal: begin
                        is_jump    = 1'b1;
                        pc_write   = 1'b1;
                        reg_write  = (op_q == OpJal);
                        link_to_pc = (op_q == OpJal);
                        retired    = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                mem_read  = (op_q == OpLw);
                mem_write = (op_q == OpSw);
                retired   = (op_q == OpSw) && mem_ready;
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OpLw);
                reg_dst    = (op_q == OpR);
                retired    = 1'b1;
            end
            default: ;
        endcase

        // A reset cycle aborts the instruction: nothing may commit or write memory.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            retired   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven per-cycle bench for multicycle_control with an expected-output queue.
module tb_multicycle_control;

    // Enable bit positions in the packed expectation, MSB first.
    localparam logic [11:0] PCW = 12'h800;
    localparam logic [11:0] IRW = 12'h400;
    localparam logic [11:0] MR  = 12'h200;
    localparam logic [11:0] MW  = 12'h100;
    localparam logic [11:0] RW  = 12'h080;
    localparam logic [11:0] AS  = 12'h040;
    localparam logic [11:0] M2R = 12'h020;
    localparam logic [11:0] L2P = 12'h010;
    localparam logic [11:0] RD  = 12'h008;
    localparam logic [11:0] BR  = 12'h004;
    localparam logic [11:0] JMP = 12'h002;
    localparam logic [11:0] JR  = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    logic       clk, reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, alu_src;
    logic       mem_to_reg, link_to_pc, reg_dst, is_branch, is_jump, jr_sel;
    logic [2:0] command;
    logic       retired, trap;
    logic [2:0] state;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .link_to_pc(link_to_pc),
        .reg_dst(reg_dst), .is_branch(is_branch), .is_jump(is_jump), .jr_sel(jr_sel),
        .command(command), .retired(retired), .trap(trap), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [19:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // {enables, command, retired, trap, state}
    function automatic logic [19:0] pk(input int st, input logic [11:0] en, input int cmd,
                                       input bit ret);
        logic [2:0] c3, s3;
        c3 = cmd[2:0];
        s3 = st[2:0];
        return {en, c3, ret, (st == 5), s3};
    endfunction

    function automatic vec_t mk(input string nm, input bit rst, input logic [5:0] op,
                                input logic [5:0] fn, input bit z, input bit rdy, input int st,
                                input logic [11:0] en, input int cmd, input bit ret);
        vec_t v;
        v.name = nm; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.exp  = pk(st, en, cmd, ret);
        return v;
    endfunction

    task automatic add(input string nm, input bit rst, input logic [5:0] op,
                       input logic [5:0] fn, input bit z, input bit rdy, input int st,
                       input logic [11:0] en, input int cmd, input bit ret);
        vecs.push_back(mk(nm, rst, op, fn, z, rdy, st, en, cmd, ret));
    endtask

    // Fetch (ready) and decode rows shared by every instruction.
    task automatic fd(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input bit z);
        add({nm, ":F"}, 0, op, fn, z, 1, 0, PCW | IRW | MR, 0, 0);
        add({nm, ":D"}, 0, op, fn, z, 1, 1, NONE, 0, 0);
    endtask

    // Drive one cycle, queue its expectation, compare mid-cycle, advance.
    task automatic run(input vec_t v);
        logic [19:0] act, e;
        reset = v.rst; opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        #4;
        act = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg,
               link_to_pc, reg_dst, is_branch, is_jump, jr_sel, command, retired, trap, state};
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %05h want %05h", v.name, act, e);
        end
        checks++;
        if ((mem_read & mem_write) !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_wr_excl: got rd=%b wr=%b want not both", v.name, mem_read,
                     mem_write);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input bit rst, input logic [5:0] op,
                        input logic [5:0] fn, input bit z, input bit rdy, input int st,
                        input logic [11:0] en, input int cmd, input bit ret);
        run(mk(nm, rst, op, fn, z, rdy, st, en, cmd, ret));
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset cycle with ready high: no fetch commit while reset is held.
        add("reset", 1, 6'h00, 6'h20, 0, 1, 0, MR, 0, 0);

        fd("add", 6'h00, 6'h20, 0);
        add("add:E", 0, 6'h00, 6'h20, 0, 1, 2, NONE, 0, 0);
        add("add:W", 0, 6'h00, 6'h20, 0, 1, 4, RW | RD, 0, 1);

        fd("sub", 6'h00, 6'h22, 0);
        add("sub:E", 0, 6'h00, 6'h22, 0, 1, 2, NONE, 1, 0);
        add("sub:W", 0, 6'h00, 6'h22, 0, 1, 4, RW | RD, 0, 1);

        fd("slt", 6'h00, 6'h2A, 0);
        add("slt:E", 0, 6'h00, 6'h2A, 0, 1, 2, NONE, 3, 0);
        add("slt:W", 0, 6'h00, 6'h2A, 0, 1, 4, RW | RD, 0, 1);

        fd("addi", 6'h08, 6'h00, 0);
        add("addi:E", 0, 6'h08, 6'h00, 0, 1, 2, AS, 0, 0);
        add("addi:W", 0, 6'h08, 6'h00, 0, 1, 4, RW, 0, 1);

        fd("xori", 6'h0E, 6'h00, 0);
        add("xori:E", 0, 6'h0E, 6'h00, 0, 1, 2, AS, 2, 0);
        add("xori:W", 0, 6'h0E, 6'h00, 0, 1, 4, RW, 0, 1);

        // LW with three stalled MEM cycles: eight cycles in all.
        fd("lw", 6'h23, 6'h00, 0);
        add("lw:E", 0, 6'h23, 6'h00, 0, 1, 2, AS, 0, 0);
        for (int i = 0; i < 3; i++) add("lw:Mwait", 0, 6'h23, 6'h00, 0, 0, 3, MR, 0, 0);
        add("lw:M", 0, 6'h23, 6'h00, 0, 1, 3, MR, 0, 0);
        add("lw:W", 0, 6'h23, 6'h00, 0, 1, 4, RW | M2R, 0, 1);

        fd("sw", 6'h2B, 6'h00, 0);
        add("sw:E", 0, 6'h2B, 6'h00, 0, 1, 2, AS, 0, 0);
        add("sw:M", 0, 6'h2B, 6'h00, 0, 1, 3, MW, 0, 1);

        fd("beq1", 6'h04, 6'h00, 1);
        add("beq1:E", 0, 6'h04, 6'h00, 1, 1, 2, PCW | BR, 1, 1);
        fd("beq0", 6'h04, 6'h00, 0);
        add("beq0:E", 0, 6'h04, 6'h00, 0, 1, 2, BR, 1, 1);
        fd("bne1", 6'h05, 6'h00, 1);
        add("bne1:E", 0, 6'h05, 6'h00, 1, 1, 2, BR, 1, 1);
        fd("bne0", 6'h05, 6'h00, 0);
        add("bne0:E", 0, 6'h05, 6'h00, 0, 1, 2, PCW | BR, 1, 1);

        fd("j", 6'h02, 6'h00, 0);
        add("j:E", 0, 6'h02, 6'h00, 0, 1, 2, PCW | JMP, 0, 1);
        fd("jal", 6'h03, 6'h00, 0);
        add("jal:E", 0, 6'h03, 6'h00, 0, 1, 2, PCW | JMP | RW | L2P, 0, 1);
        fd("jr", 6'h00, 6'h08, 0);
        add("jr:E", 0, 6'h00, 6'h08, 0, 1, 2, PCW | JMP | JR, 0, 1);

        // Fetch stall of two cycles before an ADD.
        for (int i = 0; i < 2; i++) add("fstall", 0, 6'h00, 6'h20, 0, 0, 0, MR, 0, 0);
        fd("add2", 6'h00, 6'h20, 0);
        add("add2:E", 0, 6'h00, 6'h20, 0, 1, 2, NONE, 0, 0);
        add("add2:W", 0, 6'h00, 6'h20, 0, 1, 4, RW | RD, 0, 1);

        // Illegal opcode traps; TRAP ignores ready until reset.
        fd("ill", 6'h3F, 6'h00, 0);
        for (int i = 0; i < 10; i++) add("trap_hold", 0, 6'h3F, 6'h00, 0, 1, 5, NONE, 0, 0);
        add("trap_rst", 1, 6'h3F, 6'h00, 0, 1, 5, NONE, 0, 0);
        add("after_rst", 0, 6'h00, 6'h20, 0, 0, 0, MR, 0, 0);

        foreach (vecs[i]) run(vecs[i]);

        // Reset while SW sits in MEM with ready high: no write, back to FETCH.
        step("swr:F", 0, 6'h2B, 6'h00, 0, 1, 0, PCW | IRW | MR, 0, 0);
        step("swr:D", 0, 6'h2B, 6'h00, 0, 1, 1, NONE, 0, 0);
        step("swr:E", 0, 6'h2B, 6'h00, 0, 1, 2, AS, 0, 0);
        step("swr:Mrst", 1, 6'h2B, 6'h00, 0, 1, 3, NONE, 0, 0);
        step("swr:F2", 0, 6'h2B, 6'h00, 0, 0, 0, MR, 0, 0);

        // Long stalls in FETCH then MEM: counter must clear between them.
        for (int i = 0; i < 10; i++) step("clr:Fw", 0, 6'h2B, 6'h00, 0, 0, 0, MR, 0, 0);
        step("clr:F", 0, 6'h2B, 6'h00, 0, 1, 0, PCW | IRW | MR, 0, 0);
        step("clr:D", 0, 6'h2B, 6'h00, 0, 1, 1, NONE, 0, 0);
        step("clr:E", 0, 6'h2B, 6'h00, 0, 1, 2, AS, 0, 0);
        for (int i = 0; i < 10; i++) step("clr:Mw", 0, 6'h2B, 6'h00, 0, 0, 3, MW, 0, 0);
        step("clr:M", 0, 6'h2B, 6'h00, 0, 1, 3, MW, 0, 1);

        // MEM timeout on LW: 15 stalled cycles, then TRAP.
        step("mto:F", 0, 6'h23, 6'h00, 0, 1, 0, PCW | IRW | MR, 0, 0);
        step("mto:D", 0, 6'h23, 6'h00, 0, 1, 1, NONE, 0, 0);
        step("mto:E", 0, 6'h23, 6'h00, 0, 1, 2, AS, 0, 0);
        for (int i = 0; i < 15; i++) step("mto:Mw", 0, 6'h23, 6'h00, 0, 0, 3, MR, 0, 0);
        step("mto:trap", 0, 6'h23, 6'h00, 0, 0, 5, NONE, 0, 0);
        step("mto:rst", 1, 6'h23, 6'h00, 0, 0, 5, NONE, 0, 0);

        // FETCH timeout: 15 stalled cycles, TRAP on the next.
        for (int i = 0; i < 15; i++) step("fto:Fw", 0, 6'h00, 6'h20, 0, 0, 0, MR, 0, 0);
        step("fto:trap", 0, 6'h00, 6'h20, 0, 1, 5, NONE, 0, 0);
        step("fto:rst", 1, 6'h00, 6'h20, 0, 1, 5, NONE, 0, 0);
        step("fto:F", 0, 6'h00, 6'h20, 0, 0, 0, MR, 0, 0);

        // Illegal funct under opcode 00 also traps.
        step("ilf:F", 0, 6'h00, 6'h3F, 0, 1, 0, PCW | IRW | MR, 0, 0);
        step("ilf:D", 0, 6'h00, 6'h3F, 0, 1, 1, NONE, 0, 0);
        step("ilf:trap", 0, 6'h00, 6'h3F, 0, 1, 5, NONE, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
